// File: rtl/cache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter
//
// Shares one sram-like memory port (toward the sram-to-AXI bridge) between
// the instruction cache and the data cache. Exactly one requester owns the
// port per transaction, from its address phase until mem_data_ok. The
// handshakes are routed back to that owner only.
//
// Arbitration happens combinationally in IDLE. The granted requester's
// request is presented on mem_* in the same cycle, so there is no arbitration
// latency.
//
// Parameters
//   ARB_MODE      0 = fixed priority (data over inst, with starvation guard)
//                 1 = round-robin on ties
//   STARVE_LIMIT  mode 0: consecutive data grants with inst pending before
//                 inst is forced through (1..15)
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   inst_* / data_*               sram-like slave ports toward the two caches
//                                 (req/wr/size/addr/wdata in,
//                                 rdata/addr_ok/data_ok out)
//   mem_*                         sram-like master port toward the bridge
//   owner                         current/last grant (0 = inst, 1 = data)
//   busy                          transaction in flight past the grant cycle
// -----------------------------------------------------------------------------
module cache_bus_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,

    output logic        owner,
    output logic        busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic [3:0] starve_cnt;

    logic       grant;       // arbitration result, meaningful in IDLE only
    logic       idle_grant;  // a grant is issued this cycle
    logic       sel;         // requester currently driving mem_*
    logic       addr_phase;  // address handshake may complete this cycle
    logic       data_phase;  // data handshake may complete this cycle

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        grant = data_req;
        if (inst_req && data_req) begin
            if (ARB_MODE == 1) begin
                grant = ~last_grant;
            end else begin
                // Data normally wins; inst is forced through once it has
                // been passed over STARVE_LIMIT times in a row.
                grant = (starve_cnt == LIMIT) ? 1'b0 : 1'b1;
            end
        end
    end

    // Qualified by rst so that an asserted reset silences the port even
    // while the caches still hold their request lines.
    assign idle_grant = rst && (state == IDLE) && (inst_req || data_req);
    assign sel        = (state == IDLE) ? grant : owner;
    assign addr_phase = idle_grant || (state == ADDR);
    assign data_phase = idle_grant || (state == ADDR) || (state == DATA);

    // -------------------------------------------------------------------------
    // Memory-side request mux
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req   = addr_phase;
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (addr_phase) begin
            if (sel) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake routing: the non-owner never sees an ok
    // -------------------------------------------------------------------------
    assign inst_addr_ok = addr_phase && !sel && mem_addr_ok;
    assign data_addr_ok = addr_phase &&  sel && mem_addr_ok;
    assign inst_data_ok = data_phase && !sel && mem_data_ok;
    assign data_data_ok = data_phase &&  sel && mem_data_ok;

    // Read data is a plain passthrough; data_ok alone qualifies it.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Transaction FSM and arbitration history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_grant) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (ARB_MODE == 0) begin
                            if (!grant) begin
                                starve_cnt <= 4'd0;
                            end else if (inst_req && (starve_cnt != LIMIT)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                        // Both handshakes in the grant cycle finish the
                        // transaction without ever leaving IDLE.
                        if (mem_addr_ok) begin
                            state <= mem_data_ok ? IDLE : DATA;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        state <= mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    // fixed-priority instance outputs
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, owner, busy;
    logic [1:0]  mem_size;

    // round-robin instance outputs
    logic [31:0] inst_rdata_r, data_rdata_r, mem_addr_r, mem_wdata_r;
    logic        inst_addr_ok_r, inst_data_ok_r, data_addr_ok_r, data_data_ok_r;
    logic        mem_req_r, mem_wr_r, owner_r, busy_r;
    logic [1:0]  mem_size_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .owner(owner), .busy(busy)
    );

    cache_bus_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_r),
        .inst_addr_ok(inst_addr_ok_r), .inst_data_ok(inst_data_ok_r),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata_r),
        .data_addr_ok(data_addr_ok_r), .data_data_ok(data_data_ok_r),
        .mem_req(mem_req_r), .mem_wr(mem_wr_r), .mem_size(mem_size_r),
        .mem_addr(mem_addr_r), .mem_wdata(mem_wdata_r), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .owner(owner_r), .busy(busy_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_fp;
        logic [9:0] exp_rr;
        logic       g;

        rst = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'b10;
        inst_addr = 32'h0000_1000; inst_wdata = 32'h1111_1111;
        data_req = 0; data_wr = 0; data_size = 2'b10;
        data_addr = 32'h1FC0_0010; data_wdata = 32'h2222_2222;
        mem_rdata = 32'h0; mem_addr_ok = 0; mem_data_ok = 0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_owner",   32'(owner), 32'd1);
        chk("rst_owner_rr", 32'(owner_r), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'h0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // ---------------- single data read ----------------
        data_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk("rd_c0_mem_req",  32'(mem_req), 32'd1);
        chk("rd_c0_mem_addr", mem_addr, 32'h1FC0_0010);
        chk("rd_c0_mem_size", 32'(mem_size), 32'd2);
        chk("rd_c0_d_aok",    32'(data_addr_ok), 32'd1);
        chk("rd_c0_i_aok",    32'(inst_addr_ok), 32'd0);
        chk("rd_c0_busy",     32'(busy), 32'd0);
        next_cycle();
        data_req = 0; mem_addr_ok = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("rd_wait_busy",   32'(busy), 32'd1);
            chk("rd_wait_memreq", 32'(mem_req), 32'd0);
            chk("rd_wait_d_dok",  32'(data_data_ok), 32'd0);
            next_cycle();
        end
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_c3_d_dok",  32'(data_data_ok), 32'd1);
        chk("rd_c3_i_dok",  32'(inst_data_ok), 32'd0);
        chk("rd_c3_rdata",  data_rdata, 32'hDEAD_BEEF);
        chk("rd_c3_busy",   32'(busy), 32'd1);
        next_cycle();
        // stray data_ok with no grant must be ignored
        @(negedge clk);
        chk("rd_c4_busy",   32'(busy), 32'd0);
        chk("rd_c4_owner",  32'(owner), 32'd1);
        chk("idle_dok_d",   32'(data_data_ok), 32'd0);
        chk("idle_dok_i",   32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 0;

        // ------- simultaneous requests, one-cycle transactions -------
        // bit k = grant in cycle k (1 = data)
        exp_fp = 10'b0111101111;
        exp_rr = 10'b1010101010;
        inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g = exp_fp[k];
            chk("fp_mem_addr", mem_addr, g ? 32'h0000_2000 : 32'h0000_1000);
            chk("fp_d_aok", 32'(data_addr_ok), 32'(g));
            chk("fp_i_aok", 32'(inst_addr_ok), 32'(!g));
            chk("fp_d_dok", 32'(data_data_ok), 32'(g));
            chk("fp_i_dok", 32'(inst_data_ok), 32'(!g));
            chk("fp_busy",  32'(busy), 32'd0);
            if (k > 0) chk("fp_owner", 32'(owner), 32'(exp_fp[k-1]));
            g = exp_rr[k];
            chk("rr_mem_addr", mem_addr_r, g ? 32'h0000_2000 : 32'h0000_1000);
            chk("rr_d_dok", 32'(data_data_ok_r), 32'(g));
            chk("rr_i_dok", 32'(inst_data_ok_r), 32'(!g));
            chk("rr_busy",  32'(busy_r), 32'd0);
            next_cycle();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        chk("fp_owner_last", 32'(owner), 32'd0);
        chk("fp_idle_req",   32'(mem_req), 32'd0);
        next_cycle();

        // ---------------- addr_ok stall with data write ----------------
        data_req = 1; data_wr = 1; data_size = 2'b01; data_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) inst_req = 1;
            @(negedge clk);
            chk("st_mem_req",  32'(mem_req), 32'd1);
            chk("st_mem_addr", mem_addr, 32'h0000_2000);
            chk("st_i_aok",    32'(inst_addr_ok), 32'd0);
            chk("st_d_aok",    32'(data_addr_ok), 32'd0);
            if (c > 0) begin
                chk("st_owner", 32'(owner), 32'd1);
                chk("st_busy",  32'(busy), 32'd1);
            end
            next_cycle();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        chk("st_d_aok_rise", 32'(data_addr_ok), 32'd1);
        chk("st_mem_wr",     32'(mem_wr), 32'd1);
        chk("st_mem_size",   32'(mem_size), 32'd1);
        chk("st_mem_wdata",  mem_wdata, 32'hCAFE_F00D);
        chk("st_i_aok_hold", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        data_req = 0; data_wr = 0; data_size = 2'b10;
        mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("st_data_memreq", 32'(mem_req), 32'd0);
        chk("st_d_dok", 32'(data_data_ok), 32'd1);
        chk("st_i_dok", 32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 0; mem_addr_ok = 1;
        @(negedge clk);
        chk("b2b_mem_addr", mem_addr, 32'h0000_1000);
        chk("b2b_mem_size", 32'(mem_size), 32'd2);
        chk("b2b_mem_wr",   32'(mem_wr), 32'd0);
        chk("b2b_i_aok",    32'(inst_addr_ok), 32'd1);
        chk("b2b_d_aok",    32'(data_addr_ok), 32'd0);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("b2b_owner", 32'(owner), 32'd0);
        chk("b2b_i_dok", 32'(inst_data_ok), 32'd1);
        chk("b2b_d_dok", 32'(data_data_ok), 32'd0);
        chk("b2b_rdata", inst_rdata, 32'h1234_5678);
        next_cycle();
        mem_data_ok = 0;
        next_cycle();

        // ---------------- async reset in DATA ----------------
        inst_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk("ar_i_aok", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        mem_addr_ok = 1; mem_data_ok = 0;
        @(negedge clk);
        chk("ar_pre_busy",  32'(busy), 32'd1);
        chk("ar_pre_owner", 32'(owner), 32'd0);
        next_cycle();
        mem_data_ok = 1;
        #1;
        rst = 1'b0;
        #1;
        chk("ar_mem_req", 32'(mem_req), 32'd0);
        chk("ar_busy",    32'(busy), 32'd0);
        chk("ar_i_dok",   32'(inst_data_ok), 32'd0);
        chk("ar_i_aok",   32'(inst_addr_ok), 32'd0);
        chk("ar_owner",   32'(owner), 32'd1);
        chk("ar_owner_rr", 32'(owner_r), 32'd1);
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        data_req = 1; data_addr = 32'h0000_3000; mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk);
        chk("ar_post_addr",  mem_addr, 32'h0000_3000);
        chk("ar_post_d_aok", 32'(data_addr_ok), 32'd1);
        chk("ar_post_d_dok", 32'(data_data_ok), 32'd1);
        next_cycle();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        chk("ar_post_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
